// File: rtl/ref_fetch_buffer_if.sv
// Bundle of the command, DRAM read-port and DPM read-stream signals around
// the reference-pixel fetch buffer. The buffer uses the slave view; the
// prefetcher/DRAM/DPM side (or a bench) uses the master view.
interface ref_fetch_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);
  // Prefetcher command
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  // DRAM read port
  logic              dram_req;
  logic [ADDR_W-1:0] dram_addr;
  logic [LEN_W-1:0]  dram_len;
  logic              dram_ack;
  logic              dram_data_valid;
  logic [DATA_W-1:0] dram_data_in;

  // DPM read stream
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              tile_ready;
  logic [LEN_W-1:0]  tile_len;

  // Sticky protocol error
  logic              error;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len,
    input  dram_ack, dram_data_valid, dram_data_in,
    input  rd_en,
    output cmd_ready,
    output dram_req, dram_addr, dram_len,
    output rd_data, rd_data_valid, tile_ready, tile_len,
    output error
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len,
    output dram_ack, dram_data_valid, dram_data_in,
    output rd_en,
    input  cmd_ready,
    input  dram_req, dram_addr, dram_len,
    input  rd_data, rd_data_valid, tile_ready, tile_len,
    input  error
  );
endinterface

// File: rtl/ref_fetch_buffer.sv
// Reference-pixel fetch buffer: accepts tile-fetch commands, runs the DRAM
// request/ack handshake, captures the returned words into one of two banks,
// and streams completed tiles to the DPM. Filling one bank overlaps draining
// the other.
//
// Fill FSM states:
//   state  | meaning
//   S_IDLE | waiting for a command; ready only while the write bank is empty
//   S_REQ  | dram_req asserted, waiting for dram_ack
//   S_RECV | capturing returned words into the write bank
module ref_fetch_buffer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int BUF_WORDS = 64
) (
  input logic                   clk,
  input logic                   rst_n,
  ref_fetch_buffer_if.slave     bus
);

  localparam int IDX_W = $clog2(BUF_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RECV = 2'd2
  } state_e;

  state_e            state_q, state_d;

  // Bank bookkeeping: wb = bank being filled next, hb = bank being drained
  logic              wb_q, wb_d;
  logic              hb_q, hb_d;
  logic [1:0]        full_q, full_d;
  logic [LEN_W-1:0]  len_q [2];
  logic [LEN_W-1:0]  len_d [2];

  // Fill and drain word indices
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  ri_q, ri_d;

  // Latched request presented on the DRAM port
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  dlen_q, dlen_d;

  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  // Both banks in one array; the bank number is the top index bit
  logic [DATA_W-1:0] mem_q [2*BUF_WORDS];

  logic              cmd_ready;
  logic              len_bad;
  logic              fill_beat;
  logic              rd_fire;

  // Ready depends only on registered state, so a bank freed by a drain this
  // cycle is offered to the prefetcher on the following cycle.
  assign cmd_ready = (state_q == S_IDLE) && !full_q[wb_q];
  assign len_bad   = (bus.cmd_len == '0) || (bus.cmd_len > LEN_W'(BUF_WORDS));
  assign rd_fire   = bus.rd_en && full_q[hb_q];

  // Next-state logic for the fill FSM, bank flags, drain pointer and error
  always_comb begin
    state_d   = state_q;
    wb_d      = wb_q;
    hb_d      = hb_q;
    full_d    = full_q;
    len_d[0]  = len_q[0];
    len_d[1]  = len_q[1];
    cnt_d     = cnt_q;
    ri_d      = ri_q;
    addr_d    = addr_q;
    dlen_d    = dlen_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    fill_beat = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          if (len_bad) begin
            err_d = 1'b1;
          end else begin
            addr_d  = bus.cmd_addr;
            dlen_d  = bus.cmd_len;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.dram_ack) begin
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (bus.dram_data_valid) begin
          fill_beat = 1'b1;
          cnt_d     = cnt_q + LEN_W'(1);
          if (cnt_q == dlen_q - LEN_W'(1)) begin
            full_d[wb_q] = 1'b1;
            len_d[wb_q]  = dlen_q;
            wb_d         = ~wb_q;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Words arriving when no transfer is in flight are dropped and flagged
    if (bus.dram_data_valid && (state_q != S_RECV)) begin
      err_d = 1'b1;
    end

    // Drain of the head bank; fill and drain always touch different banks
    // because a bank is only filled while empty and only drained while full.
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = mem_q[{hb_q, ri_q[IDX_W-1:0]}];
      if (ri_q == len_q[hb_q] - LEN_W'(1)) begin
        full_d[hb_q] = 1'b0;
        ri_d         = '0;
        hb_d         = ~hb_q;
      end else begin
        ri_d = ri_q + LEN_W'(1);
      end
    end
  end

  // Control and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wb_q     <= 1'b0;
      hb_q     <= 1'b0;
      full_q   <= 2'b00;
      len_q[0] <= '0;
      len_q[1] <= '0;
      cnt_q    <= '0;
      ri_q     <= '0;
      addr_q   <= '0;
      dlen_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wb_q     <= wb_d;
      hb_q     <= hb_d;
      full_q   <= full_d;
      len_q[0] <= len_d[0];
      len_q[1] <= len_d[1];
      cnt_q    <= cnt_d;
      ri_q     <= ri_d;
      addr_q   <= addr_d;
      dlen_q   <= dlen_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Bank storage write; contents need no reset since full flags gate reads
  always_ff @(posedge clk) begin
    if (fill_beat) begin
      mem_q[{wb_q, cnt_q[IDX_W-1:0]}] <= bus.dram_data_in;
    end
  end

  assign bus.cmd_ready     = cmd_ready;
  assign bus.dram_req      = (state_q == S_REQ);
  assign bus.dram_addr     = addr_q;
  assign bus.dram_len      = dlen_q;
  assign bus.rd_data       = rdata_q;
  assign bus.rd_data_valid = rvalid_q;
  assign bus.tile_ready    = full_q[hb_q];
  assign bus.tile_len      = full_q[hb_q] ? len_q[hb_q] : '0;
  assign bus.error         = err_q;

endmodule
